// File: rtl/factorial_decode_if.sv
// Handshake bundle for factorial_decode: input word channel and decoded result channel.
// out_sat exists only when FACT_DEC_SAT_EN is defined.
interface factorial_decode_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_n;
  logic             out_exact;
`ifdef FACT_DEC_SAT_EN
  logic             out_sat;
`endif

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_n, out_exact
`ifdef FACT_DEC_SAT_EN
    , input out_sat
`endif
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_n, out_exact
`ifdef FACT_DEC_SAT_EN
    , output out_sat
`endif
  );
endinterface

// File: rtl/factorial_decode.sv
// Iterative inverse factorial: finds the largest k<=MAX_N with f(k)<=value, f(0)=0, f(k)=k!.
// Optional out_sat flag (value > MAX_N!) compiled in with FACT_DEC_SAT_EN.
module factorial_decode #(
  parameter int WIDTH = 32,
  parameter int MAX_N = 12
) (
  input  logic            clk,
  input  logic            reset,
  factorial_decode_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] p;
  logic [3:0]       k;
  logic [3:0]       k1;
  logic [WIDTH+3:0] nxt;
  logic             last;

  // k+1 never exceeds 15 while nxt matters (k<MAX_N<=15), so WIDTH+4 bits hold the product.
  assign k1   = k + 4'd1;
  assign nxt  = {4'b0, p} * {{WIDTH{1'b0}}, k1};
  assign last = (k == 4'(MAX_N)) || (nxt > {4'b0, v});

  assign bus.in_ready = (state == IDLE);

`ifdef FACT_DEC_SAT_EN
  function automatic logic [WIDTH-1:0] fact(input int n);
    logic [WIDTH-1:0] r;
    if (n == 0) return '0;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * WIDTH'(i);
    return r;
  endfunction

  localparam logic [WIDTH-1:0] FMAX = fact(MAX_N);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      v             <= '0;
      p             <= '0;
      k             <= '0;
      bus.out_valid <= 1'b0;
      bus.out_n     <= '0;
      bus.out_exact <= 1'b0;
`ifdef FACT_DEC_SAT_EN
      bus.out_sat   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            v     <= bus.in_value;
            p     <= WIDTH'(1);
            k     <= 4'd1;
            state <= RUN;
          end
        end
        RUN: begin
          if (v == '0) begin
            bus.out_n     <= 4'd0;
            bus.out_exact <= 1'b1;
            bus.out_valid <= 1'b1;
`ifdef FACT_DEC_SAT_EN
            bus.out_sat   <= 1'b0;
`endif
            state         <= DONE;
          end else if (last) begin
            bus.out_n     <= k;
            bus.out_exact <= (p == v);
            bus.out_valid <= 1'b1;
`ifdef FACT_DEC_SAT_EN
            bus.out_sat   <= (v > FMAX);
`endif
            state         <= DONE;
          end else begin
            p <= nxt[WIDTH-1:0];
            k <= k1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_decode.sv
// Scoreboard bench for factorial_decode: stimulus pushes expected results, a monitor
// pops and checks value, latency, hold stability and the output handshake.
module tb_factorial_decode;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  typedef struct {
    logic [3:0] n;
    logic       exact;
    logic       sat;
    int         acc;
    int         lat;
    int         hold;
  } exp_t;

  exp_t exp_q[$];

  factorial_decode_if #(.WIDTH(32)) bus ();

  factorial_decode #(.WIDTH(32), .MAX_N(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("idle_timeout", 0, 1);
  endtask

  // Presents val at the next free IDLE cycle; acceptance edge is the next posedge.
  task automatic send(input logic [31:0] val, input logic [3:0] en, input logic ex,
                      input logic sat, input int lat, input int hold);
    exp_t e;
    @(negedge clk);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_value = val;
    e.n = en; e.exact = ex; e.sat = sat; e.acc = cyc + 1; e.lat = lat; e.hold = hold;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_value = '0;
  endtask

  // Monitor: owns out_ready, checks each result as out_valid rises.
  initial begin
    exp_t e;
    logic [3:0] n0;
    logic       x0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
          bus.out_ready = 1'b1;
          @(negedge clk);
          bus.out_ready = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("out_n", bus.out_n, e.n);
          chk("out_exact", bus.out_exact, e.exact);
`ifdef FACT_DEC_SAT_EN
          chk("out_sat", bus.out_sat, e.sat);
`endif
          chk("latency", cyc - e.acc, e.lat);
          n0 = bus.out_n;
          x0 = bus.out_exact;
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_n", bus.out_n, n0);
            chk("hold_exact", bus.out_exact, x0);
          end
          bus.out_ready = 1'b1;
          @(negedge clk);
          bus.out_ready = 1'b0;
          chk("valid_cleared", bus.out_valid, 0);
          chk("ready_after_done", bus.in_ready, 1);
        end
      end
    end
  end

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_n", bus.out_n, 0);
    chk("reset_out_exact", bus.out_exact, 0);

    send(32'd120,       4'd5,  1'b1, 1'b0, 5,  3);
    send(32'd0,         4'd0,  1'b1, 1'b0, 1,  0);
    send(32'd1,         4'd1,  1'b1, 1'b0, 1,  0);
    send(32'd2,         4'd2,  1'b1, 1'b0, 2,  1);
    send(32'd5,         4'd2,  1'b0, 1'b0, 2,  0);
    send(32'd719,       4'd5,  1'b0, 1'b0, 5,  0);
    send(32'd720,       4'd6,  1'b1, 1'b0, 6,  0);
    send(32'd479001600, 4'd12, 1'b1, 1'b0, 12, 0);
    send(32'hFFFFFFFF,  4'd12, 1'b0, 1'b1, 12, 2);

    // Abort a decode of 40320 with a reset pulse at E0+3.
    @(negedge clk);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_value = 32'd40320;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    send(32'd6, 4'd3, 1'b1, 1'b0, 3, 0);

    // Hold in_valid with changing words through RUN/DONE; only 720 may be decoded.
    @(negedge clk);
    wait_idle();
    begin
      exp_t e;
      logic [31:0] junk[4];
      junk[0] = 32'd0; junk[1] = 32'd5; junk[2] = 32'hFFFFFFFF; junk[3] = 32'd24;
      bus.in_valid = 1'b1;
      bus.in_value = 32'd720;
      e.n = 4'd6; e.exact = 1'b1; e.sat = 1'b0; e.acc = cyc + 1; e.lat = 6; e.hold = 3;
      exp_q.push_back(e);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("busy_in_ready", bus.in_ready, 0);
        bus.in_value = junk[i % 4];
      end
      bus.in_valid = 1'b0;
      bus.in_value = '0;
    end

    w = 0;
    while ((exp_q.size() != 0 || !bus.in_ready || bus.out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
    chk("no_spurious_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
